cpu_clk_ctrl: RTL and testbench

Run-control and clock-enable scheduler for the one-bit CPU. It decides when the CPU core advances: free-running at a programmable divided rate, halted, single-stepped, or run for a bounded burst of steps. It replaces raw divided-clock generation with a single-cycle `cpu_ce` enable in the system clock domain. It also keeps a `slow_clk` square wave for LED/debug display.

---
 rtl/cpu_clk_ctrl_pkg.sv | 13 +
 rtl/period_counter.sv | 42 ++++
 rtl/cpu_clk_ctrl.sv | 131 +++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared types and constants for the CPU run-control / clock-enable scheduler.
package cpu_clk_ctrl_pkg;

  localparam int STATE_W           = 2;
  localparam int DIV_RESET_DEFAULT = 1_000_000;

  typedef enum logic [STATE_W-1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2
  } state_t;

endpackage

// File: rtl/period_counter.sv
// Divided-rate tick generator: latches the effective divisor and raises `tick`
// for one cycle every d enabled cycles.
module period_counter
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DIV_W     = 20,
  parameter int DIV_RESET = DIV_RESET_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  localparam logic [DIV_W-1:0] D_RST = (DIV_RESET < 1) ? DIV_W'(1) : DIV_W'(DIV_RESET);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] d_q;
  logic [DIV_W-1:0] div_eff;

  assign div_eff = (div == '0) ? DIV_W'(1) : div;
  assign tick    = enable && (cnt_q == d_q - DIV_W'(1));

  // The divisor is only re-sampled at a clear or a wrap, so a mid-period
  // change of `div` never truncates or stretches the running period.
  // NOTE: sequential state is assigned with <= so every register sees the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      d_q   <= D_RST;
    end else if (clear || tick) begin
      cnt_q <= '0;
      d_q   <= div_eff;
    end else if (enable) begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run-control FSM (HALT/RUN/BURST) producing a one-cycle cpu_ce and a slow_clk
// display toggle. Define CPU_CLK_CTRL_CYCLE_CNT_EN to add the cycle_cnt port.
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DIV_W     = 20,
  parameter int DIV_RESET = DIV_RESET_DEFAULT,
  parameter int BURST_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIV_W-1:0]   div,
  input  logic               run,
  input  logic               halt,
  input  logic               step,
  input  logic               burst,
  input  logic [BURST_W-1:0] burst_len,
  output logic               cpu_ce,
  output logic               slow_clk,
  output logic [STATE_W-1:0] state,
  output logic               halted
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
  ,
  output logic [31:0]        cycle_cnt
`endif
);

  state_t             state_q, state_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               ce_d;
  logic               clear;
  logic               cnt_en;
  logic               tick;

  assign cnt_en = (state_q == RUN) || (state_q == BURST);

  period_counter #(
    .DIV_W     (DIV_W),
    .DIV_RESET (DIV_RESET)
  ) u_period_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .enable (cnt_en),
    .div    (div),
    .tick   (tick)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ce_d    = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      HALT: begin
        if (halt) begin
          state_d = HALT;
        end else if (step) begin
          ce_d = 1'b1;
        end else if (burst && (burst_len != '0)) begin
          state_d = BURST;
          rem_d   = burst_len;
          clear   = 1'b1;
        end else if (run) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        if (halt) begin
          state_d = HALT;
          clear   = 1'b1;
        end else if (tick) begin
          ce_d = 1'b1;
        end
      end
      BURST: begin
        if (halt) begin
          state_d = HALT;
          rem_d   = '0;
          clear   = 1'b1;
        end else if (tick) begin
          ce_d = 1'b1;
          // The last step still fires, and the FSM leaves on the same edge.
          if (rem_q == BURST_W'(1)) begin
            state_d = HALT;
            rem_d   = '0;
            clear   = 1'b1;
          end else begin
            rem_d = rem_q - BURST_W'(1);
          end
        end
      end
      default: begin
        state_d = HALT;
        rem_d   = '0;
        clear   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HALT;
      rem_q    <= '0;
      cpu_ce   <= 1'b0;
      slow_clk <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      cpu_ce   <= ce_d;
      slow_clk <= slow_clk ^ ce_d;
    end
  end

`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (ce_d) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

  assign state  = state_q;
  assign halted = (state_q == HALT);

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scoreboard bench for cpu_clk_ctrl: stimulus queues the cycle and slow_clk
// level of each expected cpu_ce pulse; a negedge monitor pops and compares.
module tb_cpu_clk_ctrl;
  import cpu_clk_ctrl_pkg::*;

  localparam int DIV_W   = 20;
  localparam int BURST_W = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [DIV_W-1:0]   div = '0;
  logic               run = 1'b0, halt = 1'b0, step = 1'b0, burst = 1'b0;
  logic [BURST_W-1:0] burst_len = '0;
  logic               cpu_ce, slow_clk, halted;
  logic [STATE_W-1:0] state;
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
  logic [31:0]        cycle_cnt;
`endif

  cpu_clk_ctrl #(
    .DIV_W   (DIV_W),
    .BURST_W (BURST_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .div       (div),
    .run       (run),
    .halt      (halt),
    .step      (step),
    .burst     (burst),
    .burst_len (burst_len),
    .cpu_ce    (cpu_ce),
    .slow_clk  (slow_clk),
    .state     (state),
    .halted    (halted)
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen; a pulse "after edge N" is seen with cyc == N.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   at;
    logic slow;
  } exp_t;

  exp_t sb_q[$];
  logic exp_slow = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) step_cycles(1);
  endtask

  task automatic expect_pulse(input int at);
    exp_t e;
    exp_slow = ~exp_slow;
    e.at   = at;
    e.slow = exp_slow;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step_cycles(2);
    rst = 1'b0;
    exp_slow = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (cpu_ce === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ce", cpu_ce, 0);
      end else begin
        e = sb_q.pop_front();
        check("ce_cycle", cyc, e.at);
        check("slow_clk_at_ce", slow_clk, e.slow);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c;

    // Reset and idle
    step_cycles(2);
    rst = 1'b0;
    check("rst_state", state, 0);
    check("rst_halted", halted, 1);
    check("rst_slow_clk", slow_clk, 0);
    check("rst_cpu_ce", cpu_ce, 0);
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
    check("rst_cycle_cnt", cycle_cnt, 0);
`endif
    for (int i = 0; i < 20; i++) begin
      step_cycles(1);
      check("idle_cpu_ce", cpu_ce, 0);
    end
    check("idle_state", state, 0);

    // RUN at div=4
    div = 20'd4;
    c = cyc;
    expect_pulse(c + 5);
    expect_pulse(c + 9);
    expect_pulse(c + 13);
    run = 1'b1;
    step_cycles(1);
    run = 1'b0;
    check("run_state", state, 1);
    check("run_halted", halted, 0);
    wait_to(c + 14);
    halt = 1'b1;
    step_cycles(1);
    halt = 1'b0;
    check("run_halt_state", state, 0);
    step_cycles(6);
    check("run_slow_clk", slow_clk, exp_slow);
    check("run_sb_empty", sb_q.size(), 0);

    // Single steps
    do_reset();
    c = cyc;
    expect_pulse(c + 1);
    step = 1'b1;
    step_cycles(1);
    step = 1'b0;
    check("step1_state", state, 0);
    step_cycles(2);
    c = cyc;
    expect_pulse(c + 1);
    expect_pulse(c + 2);
    expect_pulse(c + 3);
    step = 1'b1;
    step_cycles(3);
    step = 1'b0;
    check("step3_state", state, 0);
    step_cycles(2);
    check("step_sb_empty", sb_q.size(), 0);
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
    check("step_cycle_cnt", cycle_cnt, 4);
`endif

    // Burst of 3 at div=2, then a zero-length burst
    div = 20'd2;
    burst_len = 8'd3;
    c = cyc;
    expect_pulse(c + 3);
    expect_pulse(c + 5);
    expect_pulse(c + 7);
    burst = 1'b1;
    step_cycles(1);
    burst = 1'b0;
    check("burst_state", state, 2);
    wait_to(c + 6);
    check("burst_state_before_last", state, 2);
    step_cycles(1);
    check("burst_state_at_last", state, 0);
    step_cycles(3);
    check("burst_sb_empty", sb_q.size(), 0);
    burst_len = 8'd0;
    burst = 1'b1;
    step_cycles(1);
    burst = 1'b0;
    check("burst0_state", state, 0);
    step_cycles(8);
    check("burst0_sb_empty", sb_q.size(), 0);

    // Halt on a tick cycle at div=5
    div = 20'd5;
    c = cyc;
    expect_pulse(c + 6);
    run = 1'b1;
    step_cycles(1);
    run = 1'b0;
    wait_to(c + 10);
    halt = 1'b1;
    step_cycles(1);
    halt = 1'b0;
    check("halt_tick_state", state, 0);
    step_cycles(4);
    check("halt_tick_sb_empty", sb_q.size(), 0);

    // Divisor change 5 -> 2 mid-period
    c = cyc;
    expect_pulse(c + 6);
    expect_pulse(c + 11);
    expect_pulse(c + 13);
    expect_pulse(c + 15);
    run = 1'b1;
    step_cycles(1);
    run = 1'b0;
    wait_to(c + 7);
    div = 20'd2;
    wait_to(c + 15);
    halt = 1'b1;
    step_cycles(1);
    halt = 1'b0;
    step_cycles(4);
    check("divchg_sb_empty", sb_q.size(), 0);

    // div=0 behaves as 1
    div = 20'd0;
    c = cyc;
    for (int i = 2; i <= 5; i++) expect_pulse(c + i);
    run = 1'b1;
    step_cycles(1);
    run = 1'b0;
    wait_to(c + 5);
    halt = 1'b1;
    step_cycles(1);
    halt = 1'b0;
    check("div0_state", state, 0);
    step_cycles(3);
    check("div0_sb_empty", sb_q.size(), 0);

    // run + step + burst together: step wins
    div = 20'd3;
    burst_len = 8'd5;
    c = cyc;
    expect_pulse(c + 1);
    run = 1'b1;
    step = 1'b1;
    burst = 1'b1;
    step_cycles(1);
    run = 1'b0;
    step = 1'b0;
    burst = 1'b0;
    check("prio_state", state, 0);
    step_cycles(5);
    check("prio_state_later", state, 0);
    check("prio_sb_empty", sb_q.size(), 0);

    // Reset in BURST on a tick cycle
    div = 20'd2;
    burst_len = 8'd4;
    c = cyc;
    expect_pulse(c + 3);
    expect_pulse(c + 5);
    burst = 1'b1;
    step_cycles(1);
    burst = 1'b0;
    wait_to(c + 6);
    rst = 1'b1;
    step_cycles(1);
    exp_slow = 1'b0;
    check("rst_burst_cpu_ce", cpu_ce, 0);
    check("rst_burst_state", state, 0);
    check("rst_burst_halted", halted, 1);
    check("rst_burst_slow_clk", slow_clk, 0);
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
    check("rst_burst_cycle_cnt", cycle_cnt, 0);
`endif
    rst = 1'b0;
    step_cycles(6);
    check("rst_burst_state_later", state, 0);
    check("rst_burst_sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
